free_slot_alloc: RTL and testbench

// Tag/slot allocator built around a find-zero search over a busy bitmap (1=busy, 0=free).

---
 rtl/free_slot_alloc.sv | 141 ++++++++++++++
 tb/tb_free_slot_alloc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/free_slot_alloc.sv
// Tag/slot allocator: registered busy bitmap (1=busy) that offers the lowest-numbered
// free slot each cycle, accepting one allocate and one release per clock.

module free_slot_find_zero #(
  parameter int TAGW = 7
) (
  input  logic [(1<<TAGW)-1:0] word_i,
  output logic                 found_o,
  output logic [TAGW-1:0]      idx_o
);

  localparam int SW  = 1 << TAGW;
  localparam int GWL = (TAGW >= 4) ? 4 : TAGW;
  localparam int GW  = 1 << GWL;
  localparam int NG  = SW / GW;

  logic [NG-1:0]  grp_hit;
  logic [GWL-1:0] lo_idx [NG];

  // Two-level search: lowest zero inside each group, then the lowest group holding one.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grp_hit = '0;
    for (int g = 0; g < NG; g++) begin
      grp_hit[g] = ~&word_i[g*GW +: GW];
      lo_idx[g]  = '0;
      for (int b = GW - 1; b >= 0; b--) begin
        if (!word_i[g*GW + b]) lo_idx[g] = GWL'(b);
      end
    end
  end

  always_comb begin
    found_o = |grp_hit;
    idx_o   = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (grp_hit[g]) idx_o = TAGW'(g * GW + int'(lo_idx[g]));
    end
  end

endmodule

module free_slot_alloc #(
  parameter int NSLOT = 96,
  parameter int TAGW  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_rdy,
  output logic [TAGW-1:0]  alloc_tag,
  input  logic             free_v,
  input  logic [TAGW-1:0]  free_tag,
  output logic [TAGW-1:0]  nfree,
  output logic [NSLOT-1:0] busy_map,
  output logic             err
);

  localparam int              SW      = 1 << TAGW;
  localparam logic [TAGW-1:0] NSLOT_T = TAGW'(NSLOT);
  localparam logic [SW-1:0]   ONE_W   = {{(SW-1){1'b0}}, 1'b1};

  logic [NSLOT-1:0] busy_q, busy_d;
  logic [TAGW-1:0]  nfree_q, nfree_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [SW-1:0]    busy_ext, alloc_mask, free_mask, nxt_ext;
  logic             alloc_acc, free_oor, free_dbl, free_ok;
  logic             fz_found;
  logic [TAGW-1:0]  fz_idx;

  // Slots NSLOT and above read as busy, so they are never offered and never released.
  assign busy_ext  = {{(SW-NSLOT){1'b1}}, busy_q};

  assign alloc_acc = alloc_req & rdy_q;
  assign free_oor  = free_v & (free_tag >= NSLOT_T);
  assign free_dbl  = free_v & ~free_oor & ~busy_ext[free_tag];
  assign free_ok   = free_v & ~free_oor &  busy_ext[free_tag];

  assign alloc_mask = alloc_acc ? (ONE_W << tag_q)    : '0;
  assign free_mask  = free_ok   ? (ONE_W << free_tag) : '0;

  // Freeing the slot being allocated is already a double free, so the alloc wins.
  assign nxt_ext = (busy_ext | alloc_mask) & ~free_mask;

  free_slot_find_zero #(
    .TAGW (TAGW)
  ) u_find_zero (
    .word_i  (nxt_ext),
    .found_o (fz_found),
    .idx_o   (fz_idx)
  );

  always_comb begin
    busy_d  = nxt_ext[NSLOT-1:0];
    nfree_d = nfree_q;
    unique case ({free_ok, alloc_acc})
      2'b10:   if (nfree_q != NSLOT_T) nfree_d = nfree_q + 1'b1;
      2'b01:   if (nfree_q != '0)      nfree_d = nfree_q - 1'b1;
      default: nfree_d = nfree_q;
    endcase
    rdy_d = (nfree_d != '0);
    tag_d = fz_found ? fz_idx : tag_q;
    err_d = err_q | free_oor | free_dbl;

    if (flush) begin
      busy_d  = '0;
      nfree_d = NSLOT_T;
      rdy_d   = 1'b1;
      tag_d   = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      busy_q  <= '0;
      nfree_q <= NSLOT_T;
      rdy_q   <= 1'b1;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      nfree_q <= nfree_d;
      rdy_q   <= rdy_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign busy_map  = busy_q;
  assign nfree     = nfree_q;
  assign alloc_rdy = rdy_q;
  assign alloc_tag = tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_free_slot_alloc.sv
// Directed bench for free_slot_alloc: fill, free-while-full, turnaround, release errors,
// same-cycle alloc/free of one tag, and flush/reset in the middle of a burst.

module tb_free_slot_alloc;

  localparam int NSLOT = 96;
  localparam int TAGW  = 7;

  logic             clk = 1'b0;
  logic             rst, flush, alloc_req, free_v;
  logic [TAGW-1:0]  free_tag;
  logic             alloc_rdy, err;
  logic [TAGW-1:0]  alloc_tag, nfree;
  logic [NSLOT-1:0] busy_map;

  int checks = 0;
  int errors = 0;

  free_slot_alloc #(.NSLOT(NSLOT), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alloc_req (alloc_req),
    .alloc_rdy (alloc_rdy),
    .alloc_tag (alloc_tag),
    .free_v    (free_v),
    .free_tag  (free_tag),
    .nfree     (nfree),
    .busy_map  (busy_map),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [NSLOT-1:0] e_busy,
                             input int e_nfree, input logic e_rdy,
                             input int e_tag, input logic e_err);
    check({tag, ".busy_map"},  128'(busy_map),  128'(e_busy));
    check({tag, ".nfree"},     128'(nfree),     128'(e_nfree));
    check({tag, ".alloc_rdy"}, 128'(alloc_rdy), 128'(e_rdy));
    check({tag, ".alloc_tag"}, 128'(alloc_tag), 128'(e_tag));
    check({tag, ".err"},       128'(err),       128'(e_err));
  endtask

  initial begin
    logic [NSLOT-1:0] all_ones;
    all_ones  = '1;
    rst       = 1'b1;
    flush     = 1'b0;
    alloc_req = 1'b1;
    free_v    = 1'b1;
    free_tag  = 7'd3;
    step();
    step();
    rst       = 1'b0;
    alloc_req = 1'b0;
    free_v    = 1'b0;
    check_state("reset", '0, 96, 1'b1, 0, 1'b0);

    // Fill: tags 0..95 back-to-back, one per cycle.
    alloc_req = 1'b1;
    for (int i = 0; i < NSLOT; i++) begin
      check("fill.rdy", 128'(alloc_rdy), 128'(1));
      check("fill.tag", 128'(alloc_tag), 128'(i));
      step();
    end
    check_state("full", all_ones, 0, 1'b0, 95, 1'b0);
    step();
    alloc_req = 1'b0;
    check_state("full_req_ignored", all_ones, 0, 1'b0, 95, 1'b0);

    // Free 37 while full, then take it back.
    free_v   = 1'b1;
    free_tag = 7'd37;
    step();
    free_v = 1'b0;
    check_state("free37", all_ones & ~(96'd1 << 37), 1, 1'b1, 37, 1'b0);
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    check_state("realloc37", all_ones, 0, 1'b0, 37, 1'b0);

    // Slots 0-9 busy, then free 4 while allocating 10.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    alloc_req = 1'b1;
    repeat (10) step();
    alloc_req = 1'b0;
    check_state("ten_busy", 96'h3FF, 86, 1'b1, 10, 1'b0);
    alloc_req = 1'b1;
    free_v    = 1'b1;
    free_tag  = 7'd4;
    step();
    alloc_req = 1'b0;
    free_v    = 1'b0;
    check_state("free4_alloc10", 96'h7EF, 86, 1'b1, 4, 1'b0);

    // Release 5, then release it again (double free), then an out-of-range tag.
    free_v   = 1'b1;
    free_tag = 7'd5;
    step();
    check_state("free5", 96'h7CF, 87, 1'b1, 4, 1'b0);
    step();
    check_state("double_free5", 96'h7CF, 87, 1'b1, 4, 1'b1);
    free_tag = 7'd100;
    step();
    free_v = 1'b0;
    check_state("free_oor", 96'h7CF, 87, 1'b1, 4, 1'b1);
    step();
    check_state("err_sticky", 96'h7CF, 87, 1'b1, 4, 1'b1);

    // Flush mid-burst: requests in the flush cycle are dropped, err holds.
    alloc_req = 1'b1;
    step();
    check_state("alloc4", 96'h7DF, 86, 1'b1, 5, 1'b1);
    flush    = 1'b1;
    free_v   = 1'b1;
    free_tag = 7'd10;
    step();
    flush  = 1'b0;
    free_v = 1'b0;
    check_state("flush", '0, 96, 1'b1, 0, 1'b1);

    // Reset mid-burst clears err as well.
    step();
    step();
    check_state("burst2", 96'h3, 94, 1'b1, 2, 1'b1);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    alloc_req = 1'b0;
    check_state("rst_mid", '0, 96, 1'b1, 0, 1'b0);

    // Alloc and free the offered tag 0 in the same cycle: double free, alloc wins.
    alloc_req = 1'b1;
    free_v    = 1'b1;
    free_tag  = 7'd0;
    step();
    alloc_req = 1'b0;
    free_v    = 1'b0;
    check_state("same_cycle_t0", 96'h1, 95, 1'b1, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
